// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for core load/store requests.
// Accepts one request at a time on a valid/ready request channel and answers
// on a valid/ready response channel a fixed LATENCY cycles later. Load data is
// returned right-aligned and zero-filled above the access size.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  request present            req_ready  high only in IDLE
//   req_wen    1 = store, 0 = load        req_addr   byte address
//   req_size   0 byte .. 3 dword          req_wdata  right-aligned store data
//   rsp_valid  response present           rsp_ready  core consumes response
//   rsp_rdata  load data (0 on store/err) rsp_err    out of range or misaligned
module dmem_responder #(
  parameter int unsigned                DATA_WIDTH = 64,
  parameter int unsigned                ADDR_WIDTH = 32,
  parameter int unsigned                DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned                LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned           IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LIMIT    = (ADDR_WIDTH+1)'(DEPTH * 8);
  localparam logic [3:0]            CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    req_ready_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Request decode, evaluated combinationally and used on the accepting edge.
  logic [ADDR_WIDTH-1:0]   off;
  logic [IDX_W-1:0]        idx;
  logic                    misaligned;
  logic                    err_d;
  logic [5:0]              shamt;
  logic [DATA_WIDTH-1:0]   size_mask;
  logic [7:0]              be_base;
  logic [7:0]              be;
  logic [DATA_WIDTH-1:0]   wdata_sh;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic                    accept;

  assign off    = req_addr - BASE_ADDR;
  assign idx    = off[3 +: IDX_W];
  assign shamt  = {req_addr[2:0], 3'b000};
  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    misaligned = 1'b0;
    size_mask  = '1;
    be_base    = 8'hFF;
    unique case (req_size)
      2'd0: begin
        size_mask = DATA_WIDTH'(64'h0000_0000_0000_00FF);
        be_base   = 8'h01;
      end
      2'd1: begin
        misaligned = req_addr[0];
        size_mask  = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
        be_base    = 8'h03;
      end
      2'd2: begin
        misaligned = |req_addr[1:0];
        size_mask  = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
        be_base    = 8'h0F;
      end
      default: begin
        misaligned = |req_addr[2:0];
        size_mask  = '1;
        be_base    = 8'hFF;
      end
    endcase
  end

  // Aligned accesses never cross the word, so shifting the enables is safe.
  assign be       = be_base << req_addr[2:0];
  assign wdata_sh = req_wdata << shamt;
  assign err_d    = (req_addr < BASE_ADDR) | ({1'b0, off} >= LIMIT) | misaligned;
  assign rdata_d  = (req_wen || err_d) ? '0 : ((mem[idx] >> shamt) & size_mask);

  // Storage is deliberately not reset; a store commits on its accepting edge.
  always_ff @(posedge clk) begin
    if (accept && req_wen && !err_d) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
            cnt_q       <= CNT_INIT;
            if (CNT_INIT == 4'd0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q     <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: one instance at LATENCY = 2 driven from
// a vector table plus corner sequences, one instance at LATENCY = 1 for
// back-to-back throughput.
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata, rsp_rdata;

  logic        req_valid1, req_ready1, req_wen1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] req_addr1;
  logic [1:0]  req_size1;
  logic [63:0] req_wdata1, rsp_rdata1;

  int tests;
  int failed;

  dmem_responder #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (32),
    .DEPTH      (4096),
    .BASE_ADDR  (32'h8000_0000),
    .LATENCY    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (32),
    .DEPTH      (4096),
    .BASE_ADDR  (32'h8000_0000),
    .LATENCY    (1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .req_wen   (req_wen1),
    .req_addr  (req_addr1),
    .req_size  (req_size1),
    .req_wdata (req_wdata1),
    .rsp_valid (rsp_valid1),
    .rsp_ready (rsp_ready1),
    .rsp_rdata (rsp_rdata1),
    .rsp_err   (rsp_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction on the LATENCY = 2 instance; hold = cycles rsp_ready is withheld.
  task automatic txn(input vec_t v, input int hold, input string tag);
    int n;
    @(negedge clk);
    chk({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_wen   = v.wen;
    req_addr  = v.addr;
    req_size  = v.size;
    req_wdata = v.wdata;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = '1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk);
      n++;
    end
    chk({tag, " latency"}, 64'(n + 1), 64'd2);
    chk({tag, " rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " err"}, 64'(rsp_err), 64'(v.exp_err));
    chk({tag, " req_ready busy"}, 64'(req_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, " hold valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, " hold rdata"}, rsp_rdata, v.exp_rdata);
      chk({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, " done valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, " done rdata"}, rsp_rdata, 64'd0);
    chk({tag, " done err"}, 64'(rsp_err), 64'd0);
    chk({tag, " done req_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    tests  = 0;
    failed = 0;

    vecs[0]  = '{1'b1, 32'h8000_0010, 2'd3, 64'h1122_3344_5566_7788, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 2'd3, 64'h0, 64'h1122_3344_5566_7788, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0013, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h8000_0012, 2'd1, 64'h0, 64'h0000_0000_0000_AB66, 1'b0};
    vecs[4]  = '{1'b0, 32'h8000_0010, 2'd3, 64'h0, 64'h1122_3344_AB66_7788, 1'b0};
    vecs[5]  = '{1'b0, 32'h8000_0002, 2'd2, 64'h0, 64'h0, 1'b1};
    vecs[6]  = '{1'b0, 32'h7FFF_FFF8, 2'd3, 64'h0, 64'h0, 1'b1};
    vecs[7]  = '{1'b1, 32'h8000_0011, 2'd1, 64'h0000_0000_0000_DEAD, 64'h0, 1'b1};
    vecs[8]  = '{1'b0, 32'h8000_0010, 2'd3, 64'h0, 64'h1122_3344_AB66_7788, 1'b0};
    vecs[9]  = '{1'b0, 32'h8000_0015, 2'd0, 64'h0, 64'h0000_0000_0000_0033, 1'b0};
    vecs[10] = '{1'b0, 32'h8000_0014, 2'd2, 64'h0, 64'h0000_0000_1122_3344, 1'b0};
    vecs[11] = '{1'b1, 32'h8000_0016, 2'd1, 64'hFFFF_FFFF_FFFF_BEEF, 64'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h8000_0010, 2'd3, 64'h0, 64'hBEEF_3344_AB66_7788, 1'b0};
    vecs[13] = '{1'b1, 32'h8000_7FF8, 2'd3, 64'hCAFE_F00D_1234_5678, 64'h0, 1'b0};
    vecs[14] = '{1'b0, 32'h8000_7FF8, 2'd3, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0};
    vecs[15] = '{1'b0, 32'h8000_8000, 2'd0, 64'h0, 64'h0, 1'b1};
    vecs[16] = '{1'b0, 32'h8000_7FFC, 2'd2, 64'h0, 64'h0000_0000_CAFE_F00D, 1'b0};

    rst        = 1'b0;
    req_valid  = 1'b0; req_wen  = 1'b0; req_addr  = '0; req_size  = '0; req_wdata  = '0; rsp_ready  = 1'b0;
    req_valid1 = 1'b0; req_wen1 = 1'b0; req_addr1 = '0; req_size1 = '0; req_wdata1 = '0; rsp_ready1 = 1'b0;

    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdata", rsp_rdata, 64'd0);
    chk("reset rsp_err", 64'(rsp_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready", 64'(req_ready), 64'd1);
    chk("post-reset req_ready L1", 64'(req_ready1), 64'd1);

    // LATENCY = 1: store then loads, req_valid held high, rsp_ready held high.
    req_valid1 = 1'b1;
    req_wen1   = 1'b1;
    req_addr1  = 32'h8000_0000;
    req_size1  = 2'd3;
    req_wdata1 = 64'h55AA_33CC_0F0F_F0F0;
    rsp_ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b req_ready %0d", i), 64'(req_ready1), 64'((i % 2) == 0));
      chk($sformatf("b2b rsp_valid %0d", i), 64'(rsp_valid1), 64'((i % 2) == 1));
      if ((i % 2) == 1) begin
        chk($sformatf("b2b rdata %0d", i), rsp_rdata1, (i == 1) ? 64'h0 : 64'h55AA_33CC_0F0F_F0F0);
        chk($sformatf("b2b err %0d", i), 64'(rsp_err1), 64'd0);
      end
      if (i == 1) req_wen1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid1 = 1'b0;
    rsp_ready1 = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      txn(vecs[i], 0, $sformatf("vec%0d", i));
    end

    // Response withheld for five cycles.
    rv = '{1'b0, 32'h8000_0010, 2'd3, 64'h0, 64'hBEEF_3344_AB66_7788, 1'b0};
    txn(rv, 5, "hold5");

    // Reset while the store response is still waiting.
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_size  = 2'd3;
    req_wdata = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midreset rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midreset rsp_valid held", 64'(rsp_valid), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("after reset req_ready %0d", i), 64'(req_ready), 64'd1);
      chk($sformatf("after reset rsp_valid %0d", i), 64'(rsp_valid), 64'd0);
    end
    rv = '{1'b0, 32'h8000_0020, 2'd3, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
    txn(rv, 0, "reload after reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
